// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request bus between the memory stage (master) and a
// variable-latency data memory (slave).
interface mem_stage_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// RV32 memory stage: turns execute-stage loads/stores into valid/ready memory
// requests, stalls upstream while in flight and registers results into writeback.
module mem_stage_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ValidE,
  input  logic                     RegWriteE,
  input  logic                     MemReadE,
  input  logic                     MemWriteE,
  input  logic [2:0]               Funct3E,
  input  logic [ADDR_WIDTH-1:0]    ALUOutE,
  input  logic [31:0]              StoreDataE,
  input  logic [RF_ADDR_WIDTH-1:0] WriteAddressE,
  output logic                     StallM,
  mem_stage_ctrl_if.master         mem,
  output logic                     ValidW,
  output logic                     RegWriteW,
  output logic [RF_ADDR_WIDTH-1:0] WriteAddressW,
  output logic [31:0]              ResultW,
  output logic                     ErrW,
  output logic [1:0]               ErrCodeW
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST_I);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  logic [1:0]               state_r;
  logic [CNT_W-1:0]         cnt_r;
  logic                     req_r;
  logic                     we_r;
  logic [ADDR_WIDTH-1:0]    mem_addr_r;
  logic [ADDR_WIDTH-1:0]    eff_addr_r;
  logic [31:0]              wdata_r;
  logic [3:0]               be_r;
  logic [2:0]               funct3_r;
  logic                     regwrite_r;
  logic [RF_ADDR_WIDTH-1:0] rd_r;

  logic                     valid_w_r;
  logic                     regwrite_w_r;
  logic [RF_ADDR_WIDTH-1:0] waddr_w_r;
  logic [31:0]              result_w_r;
  logic                     err_w_r;
  logic [1:0]               errcode_w_r;

  logic                     memop_s;
  logic                     f3_legal_s;
  logic                     misalign_s;
  logic                     start_s;
  logic [3:0]               be_s;
  logic [31:0]              wdata_s;

  // Selects the addressed lane of a load word and applies sign/zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'h00_0000, b};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = rdata;
    endcase
  endfunction

  // Execute-stage decode: legality, alignment, byte enables and store lanes.
  always_comb begin
    memop_s    = ValidE & (MemReadE | MemWriteE);
    f3_legal_s = 1'b0;
    misalign_s = 1'b0;
    be_s       = 4'b1111;
    wdata_s    = 32'h0000_0000;
    if (MemWriteE) begin
      f3_legal_s = (Funct3E == 3'b000) || (Funct3E == 3'b001) || (Funct3E == 3'b010);
    end else begin
      f3_legal_s = (Funct3E == 3'b000) || (Funct3E == 3'b001) || (Funct3E == 3'b010) ||
                   (Funct3E == 3'b100) || (Funct3E == 3'b101);
    end
    case (Funct3E[1:0])
      2'b01:   misalign_s = ALUOutE[0];
      2'b10:   misalign_s = (ALUOutE[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    if (MemWriteE) begin
      case (Funct3E[1:0])
        2'b00: begin
          be_s    = 4'b0001 << ALUOutE[1:0];
          wdata_s = {4{StoreDataE[7:0]}};
        end
        2'b01: begin
          be_s    = ALUOutE[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{StoreDataE[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = StoreDataE;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = 32'h0000_0000;
    end
    start_s = memop_s & f3_legal_s & ~misalign_s;
  end

  // Stall is combinational so the IDLE cycle of a legal access already holds execute;
  // it is gated by reset so an abandoned access releases the pipeline at once.
  always_comb begin
    if (!reset) begin
      StallM = 1'b0;
    end else if (state_r == BUSY) begin
      StallM = 1'b1;
    end else if (state_r == IDLE) begin
      StallM = start_s;
    end else begin
      StallM = 1'b0;
    end
  end

  // Access FSM, request/bus registers and writeback registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      mem_addr_r   <= '0;
      eff_addr_r   <= '0;
      wdata_r      <= 32'h0000_0000;
      be_r         <= 4'b0000;
      funct3_r     <= 3'b000;
      regwrite_r   <= 1'b0;
      rd_r         <= '0;
      valid_w_r    <= 1'b0;
      regwrite_w_r <= 1'b0;
      waddr_w_r    <= '0;
      result_w_r   <= 32'h0000_0000;
      err_w_r      <= 1'b0;
      errcode_w_r  <= ERR_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (memop_s && !start_s) begin
            valid_w_r    <= 1'b1;
            regwrite_w_r <= 1'b0;
            waddr_w_r    <= WriteAddressE;
            result_w_r   <= 32'(ALUOutE);
            err_w_r      <= 1'b1;
            errcode_w_r  <= f3_legal_s ? ERR_MISALIGN : ERR_FUNCT3;
          end else if (start_s) begin
            state_r      <= BUSY;
            cnt_r        <= '0;
            req_r        <= 1'b1;
            we_r         <= MemWriteE;
            mem_addr_r   <= {ALUOutE[ADDR_WIDTH-1:2], 2'b00};
            eff_addr_r   <= ALUOutE;
            wdata_r      <= wdata_s;
            be_r         <= be_s;
            funct3_r     <= Funct3E;
            regwrite_r   <= RegWriteE;
            rd_r         <= WriteAddressE;
            valid_w_r    <= 1'b0;
            regwrite_w_r <= 1'b0;
            waddr_w_r    <= '0;
            result_w_r   <= 32'h0000_0000;
            err_w_r      <= 1'b0;
            errcode_w_r  <= ERR_NONE;
          end else begin
            valid_w_r    <= ValidE;
            regwrite_w_r <= RegWriteE;
            waddr_w_r    <= WriteAddressE;
            result_w_r   <= 32'(ALUOutE);
            err_w_r      <= 1'b0;
            errcode_w_r  <= ERR_NONE;
          end
        end
        BUSY: begin
          if (mem.mem_ready) begin
            state_r      <= DONE;
            req_r        <= 1'b0;
            valid_w_r    <= 1'b1;
            regwrite_w_r <= regwrite_r;
            waddr_w_r    <= rd_r;
            result_w_r   <= we_r ? 32'(eff_addr_r) : load_extend(mem.mem_rdata, funct3_r, eff_addr_r[1:0]);
            err_w_r      <= 1'b0;
            errcode_w_r  <= ERR_NONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST)) begin
            state_r      <= DONE;
            req_r        <= 1'b0;
            valid_w_r    <= 1'b1;
            regwrite_w_r <= 1'b0;
            waddr_w_r    <= rd_r;
            result_w_r   <= 32'h0000_0000;
            err_w_r      <= 1'b1;
            errcode_w_r  <= ERR_TIMEOUT;
          end else begin
            cnt_r        <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          // Execute still presents the completed op here, so it must not be re-issued.
          state_r      <= IDLE;
          valid_w_r    <= 1'b0;
          regwrite_w_r <= 1'b0;
          waddr_w_r    <= '0;
          result_w_r   <= 32'h0000_0000;
          err_w_r      <= 1'b0;
          errcode_w_r  <= ERR_NONE;
        end
        default: begin
          state_r      <= IDLE;
          req_r        <= 1'b0;
          valid_w_r    <= 1'b0;
          regwrite_w_r <= 1'b0;
          err_w_r      <= 1'b0;
          errcode_w_r  <= ERR_NONE;
        end
      endcase
    end
  end

  assign mem.mem_req   = req_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = wdata_r;
  assign mem.mem_be    = be_r;

  assign ValidW        = valid_w_r;
  assign RegWriteW     = regwrite_w_r;
  assign WriteAddressW = waddr_w_r;
  assign ResultW       = result_w_r;
  assign ErrW          = err_w_r;
  assign ErrCodeW      = errcode_w_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: ALU pass-through, loads/stores with
// variable memory latency, error passes, timeout and reset abort.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ValidE = 1'b0;
  logic        RegWriteE = 1'b0;
  logic        MemReadE = 1'b0;
  logic        MemWriteE = 1'b0;
  logic [2:0]  Funct3E = 3'b000;
  logic [31:0] ALUOutE = 32'h0;
  logic [31:0] StoreDataE = 32'h0;
  logic [4:0]  WriteAddressE = 5'd0;
  logic        StallM;
  logic        ValidW;
  logic        RegWriteW;
  logic [4:0]  WriteAddressW;
  logic [31:0] ResultW;
  logic        ErrW;
  logic [1:0]  ErrCodeW;

  int errors = 0;
  int checks = 0;

  int          stall_n, req_n, pulses;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  mem_stage_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_stage_ctrl #(
    .ADDR_WIDTH(32),
    .RF_ADDR_WIDTH(5),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ValidE(ValidE),
    .RegWriteE(RegWriteE),
    .MemReadE(MemReadE),
    .MemWriteE(MemWriteE),
    .Funct3E(Funct3E),
    .ALUOutE(ALUOutE),
    .StoreDataE(StoreDataE),
    .WriteAddressE(WriteAddressE),
    .StallM(StallM),
    .mem(bus.master),
    .ValidW(ValidW),
    .RegWriteW(RegWriteW),
    .WriteAddressW(WriteAddressW),
    .ResultW(ResultW),
    .ErrW(ErrW),
    .ErrCodeW(ErrCodeW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [4:0] wa);
    ValidE = v; RegWriteE = rw; MemReadE = rd; MemWriteE = wr;
    Funct3E = f3; ALUOutE = addr; StoreDataE = sd; WriteAddressE = wa;
  endtask

  // Runs one access from its IDLE cycle; memory answers in BUSY cycle ready_at (0 = never).
  task automatic do_mem(input int ready_at, input logic [31:0] rdata);
    stall_n = 0; req_n = 0;
    cap_addr = 32'h0; cap_wdata = 32'h0; cap_be = 4'h0; cap_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (StallM) stall_n++;
      if (bus.mem_req) begin
        req_n++;
        if (req_n == 1) begin
          cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
          cap_be = bus.mem_be; cap_we = bus.mem_we;
        end
        if (req_n == ready_at) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      if (ValidW) break;
    end
  endtask

  // Drops the execute op during DONE and checks ValidW is a single-cycle pulse.
  task automatic finish_op(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    chk({tag, "_pulse_end"}, 32'(ValidW), 32'd0);
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_validw", 32'(ValidW), 32'd0);
    chk("rst_result", ResultW, 32'h0);
    chk("rst_err", {30'd0, ErrCodeW}, 32'd0);
    reset = 1'b1;
    tick();

    // ALU op passes straight through with one-cycle latency
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd7);
    #1;
    chk("alu_stall_pre", 32'(StallM), 32'd0);
    tick();
    chk("alu_validw", 32'(ValidW), 32'd1);
    chk("alu_result", ResultW, 32'h0000_1234);
    chk("alu_waddr", 32'(WriteAddressW), 32'd7);
    chk("alu_regw", 32'(RegWriteW), 32'd1);
    chk("alu_stall_post", 32'(StallM), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();

    // LB at 0x103, three BUSY cycles
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
    do_mem(3, 32'h80FF_0000);
    chk("lb_stall", 32'(stall_n), 32'd4);
    chk("lb_req", 32'(req_n), 32'd3);
    chk("lb_addr", cap_addr, 32'h0000_0100);
    chk("lb_be", 32'(cap_be), 32'hF);
    chk("lb_we", 32'(cap_we), 32'd0);
    chk("lb_result", ResultW, 32'hFFFF_FF80);
    chk("lb_validw", 32'(ValidW), 32'd1);
    chk("lb_regw", 32'(RegWriteW), 32'd1);
    chk("lb_waddr", 32'(WriteAddressW), 32'd5);
    chk("lb_done_stall", 32'(StallM), 32'd0);
    finish_op("lb");

    // LBU same address and data
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd6);
    do_mem(3, 32'h80FF_0000);
    chk("lbu_stall", 32'(stall_n), 32'd4);
    chk("lbu_result", ResultW, 32'h0000_0080);
    finish_op("lbu");

    // SH at 0x22, memory answers in the first BUSY cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 5'd0);
    do_mem(1, 32'h0);
    chk("sh_stall", 32'(stall_n), 32'd2);
    chk("sh_req", 32'(req_n), 32'd1);
    chk("sh_we", 32'(cap_we), 32'd1);
    chk("sh_be", 32'(cap_be), 32'hC);
    chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", cap_addr, 32'h0000_0020);
    chk("sh_err", 32'(ErrW), 32'd0);
    chk("sh_validw", 32'(ValidW), 32'd1);
    chk("sh_regw", 32'(RegWriteW), 32'd0);
    chk("sh_result", ResultW, 32'h0000_0022);
    finish_op("sh");

    // SB at 0x13
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h1234_56A5, 5'd0);
    do_mem(2, 32'h0);
    chk("sb_be", 32'(cap_be), 32'h8);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_stall", 32'(stall_n), 32'd3);
    finish_op("sb");

    // LH / LHU upper half, LW at aligned address
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd9);
    do_mem(1, 32'h8001_7FFF);
    chk("lh_result", ResultW, 32'hFFFF_8001);
    finish_op("lh");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd9);
    do_mem(1, 32'h8001_7FFF);
    chk("lhu_result", ResultW, 32'h0000_8001);
    finish_op("lhu");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 5'd10);
    do_mem(1, 32'h1234_5678);
    chk("lw_result", ResultW, 32'h1234_5678);
    chk("lw_waddr", 32'(WriteAddressW), 32'd10);
    finish_op("lw");

    // LW misaligned
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0041, 32'h0, 5'd3);
    #1;
    chk("mis_stall", 32'(StallM), 32'd0);
    tick();
    chk("mis_req", 32'(bus.mem_req), 32'd0);
    chk("mis_validw", 32'(ValidW), 32'd1);
    chk("mis_err", 32'(ErrW), 32'd1);
    chk("mis_code", 32'(ErrCodeW), 32'd1);
    chk("mis_regw", 32'(RegWriteW), 32'd0);

    // Illegal load funct3
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0040, 32'h0, 5'd3);
    tick();
    chk("ill_err", 32'(ErrW), 32'd1);
    chk("ill_code", 32'(ErrCodeW), 32'd2);
    chk("ill_req", 32'(bus.mem_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    chk("ill_clear", 32'(ValidW), 32'd0);

    // Timeout after 4 BUSY cycles
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd4);
    do_mem(0, 32'h0);
    chk("to_req", 32'(req_n), 32'd4);
    chk("to_stall", 32'(stall_n), 32'd5);
    chk("to_validw", 32'(ValidW), 32'd1);
    chk("to_err", 32'(ErrW), 32'd1);
    chk("to_code", 32'(ErrCodeW), 32'd3);
    chk("to_regw", 32'(RegWriteW), 32'd0);
    chk("to_stall_rel", 32'(StallM), 32'd0);
    chk("to_req_drop", 32'(bus.mem_req), 32'd0);
    finish_op("to");

    // Reset in the second BUSY cycle abandons the access
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0090, 32'h0, 5'd8);
    tick();
    chk("ra_busy_req", 32'(bus.mem_req), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("ra_req", 32'(bus.mem_req), 32'd0);
    chk("ra_stall", 32'(StallM), 32'd0);
    chk("ra_validw", 32'(ValidW), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ValidW || bus.mem_req) pulses++;
    end
    chk("ra_no_pulse", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
